// File: rtl/sha256_w_scheduler_if.sv
// ---------------------------------------------------------------------------
// sha256_w_scheduler_if
//   Stream bundle around the SHA-256 message-schedule generator.
//   Upstream channel (message words into the scheduler):
//     blk_valid  word on blk_data is valid
//     blk_ready  scheduler accepts the word this cycle
//     blk_data   32-bit message word, W[0] first
//   Downstream channel (schedule words towards the W memory):
//     w_valid    w_out / w_round are valid
//     w_ready    W memory accepts the word this cycle
//     w_out      schedule word W[t]
//     w_round    round index t, 0..63
//   Modports:
//     master  the environment: drives the upstream words and the downstream ready
//     slave   the scheduler itself
// ---------------------------------------------------------------------------
interface sha256_w_scheduler_if #(
  parameter int BIT_W = 32,
  parameter int RND_W = 7
);
  logic             blk_valid;
  logic             blk_ready;
  logic [BIT_W-1:0] blk_data;
  logic             w_valid;
  logic             w_ready;
  logic [BIT_W-1:0] w_out;
  logic [RND_W-1:0] w_round;

  modport master (
    output blk_valid, blk_data, w_ready,
    input  blk_ready, w_valid, w_out, w_round
  );

  modport slave (
    input  blk_valid, blk_data, w_ready,
    output blk_ready, w_valid, w_out, w_round
  );
endinterface

// File: rtl/sha256_w_scheduler.sv
// ---------------------------------------------------------------------------
// sha256_w_scheduler
//   SHA-256 message-schedule generator feeding the W memory stage.
//   Takes one 512-bit block as 16 streamed 32-bit words and emits W[0..63],
//   one word per downstream handshake, tagged with its round index.
//   Rounds 0-15 pass the message words straight through; rounds 16-63 are
//   expanded from a 16-word sliding window of the previously emitted words.
//
//   Ports:
//     clk    in   single clock, rising edge
//     reset  in   synchronous active-high reset, aborts any block in flight
//     start  in   begin a block (only looked at while idle)
//     bus    slave modport of sha256_w_scheduler_if (blk_* in, w_* out)
//     busy   out  high while the block is being loaded / expanded
//     done   out  one-cycle pulse after W[63] has been accepted
//
//   Build option:
//     SHA256_WSCHED_OUT_REG_EN  when defined, w_out/w_round/w_valid come from
//                               a 1-deep output register (one extra cycle of
//                               latency, full throughput kept). When undefined
//                               the outputs are combinational from the core.
// ---------------------------------------------------------------------------
module sha256_w_scheduler #(
  parameter int BIT_W  = 32,
  parameter int MEM_W  = 16,
  parameter int ROUNDS = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  sha256_w_scheduler_if.slave   bus,
  output logic                  busy,
  output logic                  done
);

  localparam int RND_W = 7;
  localparam logic [RND_W-1:0] LAST_LOAD = RND_W'(MEM_W - 1);
  localparam logic [RND_W-1:0] LAST_RND  = RND_W'(ROUNDS - 1);

  // FLUSH is only entered when the output register is built in: it waits for
  // the registered W[63] to leave before signalling done.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    EXPAND = 3'd2,
    FLUSH  = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t           state_reg;
  logic [RND_W-1:0] round_reg;

  // win_reg[0] is W[t-16], win_reg[MEM_W-1] is W[t-1].
  logic [BIT_W-1:0] win_reg  [MEM_W];
  logic [BIT_W-1:0] win_next [MEM_W];

  logic [BIT_W-1:0] s0_w;
  logic [BIT_W-1:0] s1_w;
  logic [BIT_W-1:0] exp_word;
  logic [BIT_W-1:0] core_word;
  logic             core_valid;
  logic             core_fire;
  logic             down_ready;

  function automatic logic [BIT_W-1:0] rotr(input logic [BIT_W-1:0] x, input int n);
    return (x >> n) | (x << (BIT_W - n));
  endfunction

  // -------------------------------------------------------------------------
  // Expansion: W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16], mod 2^32
  // -------------------------------------------------------------------------
  assign s0_w = rotr(win_reg[1], 7) ^ rotr(win_reg[1], 18) ^ (win_reg[1] >> 3);
  assign s1_w = rotr(win_reg[MEM_W-2], 17) ^ rotr(win_reg[MEM_W-2], 19)
              ^ (win_reg[MEM_W-2] >> 10);
  assign exp_word = s1_w + win_reg[MEM_W-7] + s0_w + win_reg[0];

  // -------------------------------------------------------------------------
  // Core word source: the upstream word while loading, the expanded word
  // while expanding; nothing is offered in any other state.
  // -------------------------------------------------------------------------
  always_comb begin
    core_valid = 1'b0;
    core_word  = '0;
    case (state_reg)
      LOAD: begin
        core_valid = bus.blk_valid;
        core_word  = bus.blk_data;
      end
      EXPAND: begin
        core_valid = 1'b1;
        core_word  = exp_word;
      end
      default: begin
        core_valid = 1'b0;
        core_word  = '0;
      end
    endcase
  end

  assign core_fire     = core_valid & down_ready;
  assign bus.blk_ready = (state_reg == LOAD) & down_ready;

  // -------------------------------------------------------------------------
  // Sliding window: every emitted word (loaded or expanded) is shifted in at
  // the top, the oldest word falls off the bottom.
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < MEM_W; gi++) begin : g_win
      if (gi == MEM_W - 1) begin : g_tail
        assign win_next[gi] = core_word;
      end else begin : g_body
        assign win_next[gi] = win_reg[gi+1];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MEM_W; i++) begin
        win_reg[i] <= '0;
      end
    end else if (core_fire) begin
      win_reg <= win_next;
    end
  end

  // -------------------------------------------------------------------------
  // Output stage
  // -------------------------------------------------------------------------
`ifdef SHA256_WSCHED_OUT_REG_EN
  logic             oreg_valid_reg;
  logic [BIT_W-1:0] oreg_word_reg;
  logic [RND_W-1:0] oreg_round_reg;

  // The core may advance when the register is empty or is being drained this
  // cycle, which keeps one word per cycle under continuous w_ready.
  assign down_ready = ~oreg_valid_reg | bus.w_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      oreg_valid_reg <= 1'b0;
      oreg_word_reg  <= '0;
      oreg_round_reg <= '0;
    end else if (down_ready) begin
      oreg_valid_reg <= core_fire;
      if (core_fire) begin
        oreg_word_reg  <= core_word;
        oreg_round_reg <= round_reg;
      end
    end
  end

  assign bus.w_valid = oreg_valid_reg;
  assign bus.w_out   = oreg_word_reg;
  assign bus.w_round = oreg_round_reg;
`else
  assign down_ready  = bus.w_ready;
  assign bus.w_valid = core_valid;
  assign bus.w_out   = core_word;
  assign bus.w_round = round_reg;
`endif

  // -------------------------------------------------------------------------
  // Control FSM. round_reg holds at 63 through the last transfer and is
  // cleared on the way back to IDLE, so it never leaves 0..63.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      round_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg <= LOAD;
          end
        end
        LOAD: begin
          if (core_fire) begin
            round_reg <= round_reg + 1'b1;
            if (round_reg == LAST_LOAD) begin
              state_reg <= EXPAND;
            end
          end
        end
        EXPAND: begin
          if (core_fire) begin
            if (round_reg == LAST_RND) begin
`ifdef SHA256_WSCHED_OUT_REG_EN
              state_reg <= FLUSH;
`else
              state_reg <= DONE;
`endif
            end else begin
              round_reg <= round_reg + 1'b1;
            end
          end
        end
        FLUSH: begin
`ifdef SHA256_WSCHED_OUT_REG_EN
          if (oreg_valid_reg && bus.w_ready) begin
            state_reg <= DONE;
          end
`else
          state_reg <= DONE;
`endif
        end
        DONE: begin
          state_reg <= IDLE;
          round_reg <= '0;
        end
        default: begin
          state_reg <= IDLE;
          round_reg <= '0;
        end
      endcase
    end
  end

  // Both decoded straight from the state register, so they are glitch-free.
  assign busy = (state_reg == LOAD) || (state_reg == EXPAND) || (state_reg == FLUSH);
  assign done = (state_reg == DONE);

endmodule

// File: tb/tb_sha256_w_scheduler.sv
// ---------------------------------------------------------------------------
// tb_sha256_w_scheduler
//   Randomised bench for sha256_w_scheduler. A driver streams blocks and
//   pushes the expected 64 (word, round) pairs into a scoreboard queue; an
//   independent monitor pops and compares on every downstream handshake and
//   also watches stall stability and the done pulse.
// ---------------------------------------------------------------------------
module tb_sha256_w_scheduler;

  typedef struct packed {
    logic [31:0] w;
    logic [6:0]  r;
  } exp_t;

`ifdef SHA256_WSCHED_OUT_REG_EN
  localparam int LAT = 66;
`else
  localparam int LAT = 65;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic busy;
  logic done;

  sha256_w_scheduler_if bus ();

  sha256_w_scheduler dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .bus   (bus),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  exp_t        sb[$];
  int          vec_cnt  = 0;
  int          miss_cnt = 0;
  int          done_cnt = 0;
  int          rdy_mode = 0;   // 0: always ready, 1: scheduled stalls, 2: random
  int          stall_left = 0;
  bit          stalled [64];
  logic [31:0] dut_w   [64];
  logic [31:0] abc     [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: straight FIPS 180-4 schedule recurrence over t.
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  task automatic push_expected(input logic [31:0] m [16]);
    logic [31:0] w [64];
    for (int t = 0; t < 64; t++) begin
      if (t < 16) w[t] = m[t];
      else w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
      sb.push_back('{w: w[t], r: 7'(t)});
    end
  endtask

  // Downstream ready generator.
  initial begin
    bus.w_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_left > 0) begin
        stall_left--;
        bus.w_ready = 1'b0;
      end else if (rdy_mode == 1 && busy &&
                   (bus.w_round == 7'd15 || bus.w_round == 7'd16 || bus.w_round == 7'd63) &&
                   !stalled[bus.w_round]) begin
        stalled[bus.w_round] = 1'b1;
        bus.w_ready = 1'b0;
        stall_left = 3;
      end else if (rdy_mode == 2) begin
        bus.w_ready = ($urandom_range(0, 3) != 0);
      end else begin
        bus.w_ready = 1'b1;
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    exp_t        e;
    logic [31:0] pw = '0;
    logic [6:0]  pr = '0;
    bit          pstall = 1'b0;
    bit          done_due = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        pstall = 1'b0;
        done_due = 1'b0;
        continue;
      end
      if (done_due) begin
        check("done_after_w63", 32'(done), 32'd1);
        done_due = 1'b0;
      end else if (done) begin
        check("done_unexpected", 32'(done), 32'd0);
      end
      if (done) done_cnt++;
      if (pstall) begin
        check("stall_valid", 32'(bus.w_valid), 32'd1);
        check("stall_word", bus.w_out, pw);
        check("stall_round", 32'(bus.w_round), 32'(pr));
      end
`ifndef SHA256_WSCHED_OUT_REG_EN
      if (busy && bus.w_round < 7'd16) begin
        check("load_valid_follows", 32'(bus.w_valid), 32'(bus.blk_valid));
      end
`endif
      if (bus.w_valid && bus.w_ready) begin
        if (sb.size() == 0) begin
          vec_cnt++;
          miss_cnt++;
          $display("FAIL sb_unexpected: got word %h round %0d, expected none", bus.w_out, bus.w_round);
        end else begin
          e = sb.pop_front();
          check("w_out", bus.w_out, e.w);
          check("w_round", 32'(bus.w_round), 32'(e.r));
          dut_w[bus.w_round[5:0]] = bus.w_out;
          if (e.r == 7'd63) done_due = 1'b1;
        end
      end
      pstall = bus.w_valid && !bus.w_ready;
      pw = bus.w_out;
      pr = bus.w_round;
    end
  end

  task automatic check_idle_outputs(input string tag);
    check({tag, "_w_valid"}, 32'(bus.w_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_blk_ready"}, 32'(bus.blk_ready), 32'd0);
    check({tag, "_w_round"}, 32'(bus.w_round), 32'd0);
    check({tag, "_w_out"}, bus.w_out, 32'd0);
  endtask

  // Streams one block. Returns one cycle after done was seen (DUT idle), or
  // after an abort reset when abort_round >= 0.
  task automatic run_block(input logic [31:0] m [16], input int gap_pct, input bit mid_start,
                           input int abort_round, input int exp_lat, input string tag);
    int idx = 0;
    int cyc = 0;
    bit xfer;
    bit seen;
    bit fin = 1'b0;
    bit aborted = 1'b0;
    for (int i = 0; i < 64; i++) stalled[i] = 1'b0;
    done_cnt = 0;
    push_expected(m);
    start = 1'b1;
    bus.blk_valid = 1'b1;
    bus.blk_data = m[0];
    while (!fin) begin
      @(negedge clk);
      xfer = bus.blk_valid && bus.blk_ready;
      seen = done;
      @(posedge clk);
      #1;
      cyc++;
      start = mid_start && busy && ($urandom_range(0, 3) == 0);
      if (xfer) idx++;
      if (idx >= 16) begin
        bus.blk_valid = 1'b0;
      end else if (!bus.blk_valid || xfer) begin
        bus.blk_valid = ($urandom_range(0, 99) >= gap_pct);
        bus.blk_data = m[idx];
      end
      if (seen) begin
        fin = 1'b1;
        if (exp_lat > 0) check({tag, "_latency"}, 32'(cyc - 1), 32'(exp_lat));
      end else if (abort_round >= 0 && busy && bus.w_round == 7'(abort_round)) begin
        reset = 1'b1;
        start = 1'b0;
        bus.blk_valid = 1'b0;
        sb.delete();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_idle_outputs({tag, "_abort"});
        check({tag, "_abort_done_cnt"}, 32'(done_cnt), 32'd0);
        @(posedge clk);
        #1;
        fin = 1'b1;
        aborted = 1'b1;
      end else if (cyc > 3000) begin
        vec_cnt++;
        miss_cnt++;
        $display("FAIL %s_timeout: got no done after %0d cycles, expected done", tag, cyc);
        fin = 1'b1;
      end
    end
    start = 1'b0;
    if (!aborted) begin
      check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
      check({tag, "_sb_left"}, 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  initial begin
    logic [31:0] rnd [16];
    bus.blk_valid = 1'b0;
    bus.blk_data = '0;
    for (int i = 0; i < 16; i++) abc[i] = 32'd0;
    abc[0] = 32'h61626380;
    abc[15] = 32'h00000018;

    // Reset held for 3 cycles, then released.
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset");
    repeat (2) @(posedge clk);
    #1;

    // "abc" block, always ready.
    rdy_mode = 0;
    run_block(abc, 0, 1'b0, -1, LAT, "abc");
    check("abc_w16", dut_w[16], 32'h61626380);
    check("abc_w17", dut_w[17], 32'h000F0000);
    check("abc_w18", dut_w[18], 32'h7DA86405);

    // Backpressure at rounds 15, 16 and 63.
    rdy_mode = 1;
    run_block(abc, 0, 1'b0, -1, 0, "bp");
    check("bp_w18", dut_w[18], 32'h7DA86405);
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;

    // Upstream gaps during LOAD.
    run_block(abc, 40, 1'b0, -1, 0, "gaps");

    // Reset mid-EXPAND, then the same block again.
    run_block(abc, 0, 1'b0, 40, 0, "abort");
    run_block(abc, 0, 1'b0, -1, LAT, "restart");

    // Stray start pulses mid-block, then a start right after done.
    run_block(abc, 0, 1'b1, -1, 0, "midstart");
    for (int i = 0; i < 16; i++) rnd[i] = $urandom;
    run_block(rnd, 0, 1'b0, -1, LAT, "backtoback");

    // Random blocks under mixed traffic.
    for (int b = 0; b < 6; b++) begin
      for (int i = 0; i < 16; i++) rnd[i] = $urandom;
      rdy_mode = $urandom_range(0, 2);
      run_block(rnd, $urandom_range(0, 50), 1'($urandom_range(0, 1)), -1, 0, "rand");
      rdy_mode = 0;
      repeat (2) @(posedge clk);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
